// File: rtl/digit_pkg.sv
// Shared types for the digit entry path: command encoding and per-slot next-value select.
package digit_pkg;

  localparam int unsigned DIGIT_W_DEFAULT = 4;

  typedef logic [DIGIT_W_DEFAULT-1:0] digit_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLR,
    CMD_COMMIT,
    CMD_PUSH,
    CMD_POP,
    CMD_HOLD
  } cmd_t;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_LOWER,
    SEL_UPPER,
    SEL_ZERO
  } slot_sel_t;

endpackage

// File: rtl/digit_slot.sv
// One digit position of the entry shift register; moves toward either neighbour or clears.
module digit_slot
  import digit_pkg::*;
#(
  parameter int unsigned DIGIT_W = DIGIT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  slot_sel_t          sel,
  input  logic [DIGIT_W-1:0] lower,
  input  logic [DIGIT_W-1:0] upper,
  output logic [DIGIT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_LOWER: q <= lower;
        SEL_UPPER: q <= upper;
        SEL_ZERO:  q <= '0;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/digit_entry_buffer.sv
// Calculator-style multi-digit entry with backspace, clear and commit; the committed
// value is held separately so the display stays stable while the next entry is typed.
module digit_entry_buffer
  import digit_pkg::*;
#(
  parameter int unsigned DIGIT_W    = DIGIT_W_DEFAULT,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DIGIT_W-1:0]                 din,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               clr,
  input  logic                               commit,
  output logic [NUM_DIGITS*DIGIT_W-1:0]      live,
  output logic [NUM_DIGITS*DIGIT_W-1:0]      dout,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    count,
  output logic                               empty,
  output logic                               full,
  output logic                               ovf,
  output logic                               done
);

  localparam int unsigned LIVE_W = NUM_DIGITS * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(NUM_DIGITS + 1);

  cmd_t             cmd_c;
  slot_sel_t        sel_c;
  logic [CNT_W-1:0] count_n_c;
  logic             ovf_n_c;
  logic             done_n_c;

  logic [LIVE_W-1:0] live_q;
  logic [LIVE_W-1:0] dout_q;
  logic [CNT_W-1:0]  count_q;
  logic              empty_q;
  logic              full_q;
  logic              ovf_q;
  logic              done_q;

  // Priority decode: clr > commit > push/pop; push with pop cancels out.
  always_comb begin
    cmd_c = CMD_NONE;
    if (clr)              cmd_c = CMD_CLR;
    else if (commit)      cmd_c = CMD_COMMIT;
    else if (push && pop) cmd_c = CMD_HOLD;
    else if (push)        cmd_c = CMD_PUSH;
    else if (pop)         cmd_c = CMD_POP;
  end

  always_comb begin
    sel_c     = SEL_HOLD;
    count_n_c = count_q;
    ovf_n_c   = 1'b0;
    done_n_c  = 1'b0;
    case (cmd_c)
      CMD_CLR: begin
        sel_c     = SEL_ZERO;
        count_n_c = '0;
      end
      CMD_COMMIT: begin
        sel_c     = SEL_ZERO;
        count_n_c = '0;
        done_n_c  = 1'b1;
      end
      CMD_PUSH: begin
        if (full_q) begin
          ovf_n_c = 1'b1;
        end else begin
          sel_c     = SEL_LOWER;
          count_n_c = count_q + CNT_W'(1);
        end
      end
      CMD_POP: begin
        if (!empty_q) begin
          sel_c     = SEL_UPPER;
          count_n_c = count_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Slot 0 takes din on a push; the top slot fills with zero on a backspace.
  for (genvar k = 0; k < int'(NUM_DIGITS); k++) begin : g_slot
    logic [DIGIT_W-1:0] lower_c;
    logic [DIGIT_W-1:0] upper_c;
    if (k == 0) begin : g_bottom
      assign lower_c = din;
    end else begin : g_lower
      assign lower_c = live_q[(k-1)*DIGIT_W +: DIGIT_W];
    end
    if (k == int'(NUM_DIGITS) - 1) begin : g_top
      assign upper_c = '0;
    end else begin : g_upper
      assign upper_c = live_q[(k+1)*DIGIT_W +: DIGIT_W];
    end
    digit_slot #(.DIGIT_W(DIGIT_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .sel   (sel_c),
      .lower (lower_c),
      .upper (upper_c),
      .q     (live_q[k*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (cmd_c == CMD_COMMIT) dout_q <= live_q;
      count_q <= count_n_c;
      empty_q <= (count_n_c == '0);
      full_q  <= (count_n_c == CNT_W'(NUM_DIGITS));
      ovf_q   <= ovf_n_c;
      done_q  <= done_n_c;
    end
  end

  assign live  = live_q;
  assign dout  = dout_q;
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign done  = done_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Scoreboard bench for digit_entry_buffer: default 4x4 instance plus a 1-bit x 8 instance.
module tb_digit_entry_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  din = '0;
  logic        push = 1'b0, pop = 1'b0, clr = 1'b0, commit = 1'b0;
  logic [15:0] live, dout;
  logic [2:0]  count;
  logic        empty, full, ovf, done;

  logic        sw_din = 1'b0;
  logic        sw_push = 1'b0;
  logic [7:0]  sw_live, sw_dout;
  logic [3:0]  sw_count;
  logic        sw_empty, sw_full, sw_ovf, sw_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  digit_entry_buffer u_dut (
    .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .clr(clr), .commit(commit),
    .live(live), .dout(dout), .count(count), .empty(empty), .full(full), .ovf(ovf), .done(done)
  );

  digit_entry_buffer #(.DIGIT_W(1), .NUM_DIGITS(8)) u_sweep (
    .clk(clk), .rst(rst), .din(sw_din), .push(sw_push), .pop(1'b0), .clr(1'b0), .commit(1'b0),
    .live(sw_live), .dout(sw_dout), .count(sw_count), .empty(sw_empty), .full(sw_full),
    .ovf(sw_ovf), .done(sw_done)
  );

  typedef struct {
    logic [15:0] live;
    logic [15:0] dout;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        done;
  } exp_t;

  typedef struct {
    logic [7:0] live;
    logic [3:0] count;
    logic       full;
    logic       ovf;
  } sw_exp_t;

  exp_t    sb[$];
  sw_exp_t sb_sw[$];

  // Reference model state, digit array form
  logic [3:0]  m_d[4];
  int          m_count = 0;
  logic [15:0] m_dout  = '0;
  logic [7:0]  s_live  = '0;
  int          s_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] m_pack();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[k*4 +: 4] = m_d[k];
    return v;
  endfunction

  task automatic compare_main();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
      return;
    end
    e = sb.pop_front();
    chk("live",  32'(live),  32'(e.live));
    chk("dout",  32'(dout),  32'(e.dout));
    chk("count", 32'(count), 32'(e.count));
    chk("empty", 32'(empty), 32'(e.empty));
    chk("full",  32'(full),  32'(e.full));
    chk("ovf",   32'(ovf),   32'(e.ovf));
    chk("done",  32'(done),  32'(e.done));
  endtask

  task automatic step(input logic r, input logic pu, input logic po, input logic cl,
                      input logic cm, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    rst = r; push = pu; pop = po; clr = cl; commit = cm; din = d;
    e.ovf = 1'b0;
    e.done = 1'b0;
    if (!r) begin
      for (int k = 0; k < 4; k++) m_d[k] = '0;
      m_count = 0;
      m_dout = '0;
      s_live = '0;
      s_count = 0;
    end else if (cl) begin
      for (int k = 0; k < 4; k++) m_d[k] = '0;
      m_count = 0;
    end else if (cm) begin
      m_dout = m_pack();
      for (int k = 0; k < 4; k++) m_d[k] = '0;
      m_count = 0;
      e.done = 1'b1;
    end else if (pu && po) begin
      // entry held
    end else if (pu) begin
      if (m_count == 4) e.ovf = 1'b1;
      else begin
        for (int k = 3; k > 0; k--) m_d[k] = m_d[k-1];
        m_d[0] = d;
        m_count++;
      end
    end else if (po) begin
      if (m_count > 0) begin
        for (int k = 0; k < 3; k++) m_d[k] = m_d[k+1];
        m_d[3] = '0;
        m_count--;
      end
    end
    e.live  = m_pack();
    e.dout  = m_dout;
    e.count = 3'(m_count);
    e.empty = (m_count == 0);
    e.full  = (m_count == 4);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_main();
  endtask

  task automatic sw_step(input logic pu, input logic b);
    sw_exp_t e;
    @(negedge clk);
    rst = 1'b1; push = 1'b0; pop = 1'b0; clr = 1'b0; commit = 1'b0;
    sw_push = pu; sw_din = b;
    e.ovf = 1'b0;
    if (pu) begin
      if (s_count == 8) e.ovf = 1'b1;
      else begin
        s_live = {s_live[6:0], b};
        s_count++;
      end
    end
    e.live  = s_live;
    e.count = 4'(s_count);
    e.full  = (s_count == 8);
    sb_sw.push_back(e);
    @(posedge clk);
    #1;
    if (sb_sw.size() == 0) chk("sw_sb_empty", 32'(1), 32'(0));
    else begin
      e = sb_sw.pop_front();
      chk("sw_live",  32'(sw_live),  32'(e.live));
      chk("sw_count", 32'(sw_count), 32'(e.count));
      chk("sw_full",  32'(sw_full),  32'(e.full));
      chk("sw_ovf",   32'(sw_ovf),   32'(e.ovf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat;
    for (int k = 0; k < 4; k++) m_d[k] = '0;

    // reset, then single-digit entry
    step(0, 0, 0, 0, 0, 4'h0);
    step(0, 1, 0, 0, 1, 4'h5);
    step(1, 1, 0, 0, 0, 4'h3);
    step(1, 1, 0, 0, 0, 4'h7);

    // overflow, then clr beats push
    step(1, 0, 0, 1, 0, 4'h0);
    for (int i = 1; i <= 5; i++) step(1, 1, 0, 0, 0, 4'(i));
    step(1, 0, 0, 0, 0, 4'h0);
    step(1, 1, 0, 1, 0, 4'hA);

    // backspace down to empty and beyond
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 0, 0, 4'(i));
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 4'hF);

    // commit, push right after, commit of empty entry
    step(1, 1, 0, 0, 0, 4'h9);
    step(1, 1, 0, 0, 0, 4'h8);
    step(1, 0, 0, 0, 1, 4'h0);
    step(1, 1, 0, 0, 0, 4'h5);
    step(1, 0, 0, 0, 0, 4'h0);

    // simultaneous commands
    step(1, 1, 1, 0, 0, 4'hC);
    step(1, 1, 0, 0, 0, 4'h1);
    step(1, 1, 0, 0, 1, 4'h6);
    step(1, 0, 0, 0, 1, 4'h0);

    // reset mid-commit
    for (int i = 1; i <= 3; i++) step(1, 1, 0, 0, 0, 4'(i));
    step(1, 0, 0, 0, 1, 4'h0);
    for (int i = 1; i <= 3; i++) step(1, 1, 0, 0, 0, 4'(i + 4));
    step(0, 0, 0, 0, 1, 4'h0);

    // random traffic against the model
    for (int i = 0; i < 80; i++) begin
      logic r;
      r = ($urandom_range(0, 30) != 0);
      step(r, 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 11) == 0),
           4'($urandom_range(0, 15)));
    end

    // 1-bit x 8 sweep: clear the sweep instance first
    step(0, 0, 0, 0, 0, 4'h0);
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) sw_step(1'b1, pat[i]);
    sw_step(1'b1, 1'b1);
    sw_step(1'b0, 1'b0);
    chk("sw_final_live", 32'(sw_live), 32'(8'hB2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/digit_entry_buffer.md
# digit_entry_buffer

Parametrised multi-digit entry register for the game's user-input path. It accepts digits one at a time with calculator-style shift entry, backspace, clear and commit, and holds the last committed number stable for the 7-segment display driver. It generalises the single 4-bit load register with the following additions:
- configurable digit width and count
- entry occupancy tracking
- overflow detection
- a separate committed output that stays stable while the player edits the next entry

## Interface
Parameters:
- DIGIT_W, 4, bits per digit (BCD/hex nibble by default)
- NUM_DIGITS, 4, digit slots; must be ≥ 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low
- din  input  DIGIT_W  digit value, sampled when push=1
- push  input  1  shift din into the entry
- pop  input  1  backspace: remove the most recently entered digit
- clr  input  1  discard the entry
- commit  input  1  transfer the entry to the committed output
- live  output  NUM_DIGITS*DIGIT_W  current entry; digit 0 occupies bits [DIGIT_W-1:0]
- dout  output  NUM_DIGITS*DIGIT_W  last committed value
- count  output  $clog2(NUM_DIGITS+1)  digits currently in the entry
- empty  output  1  count==0
- full  output  1  count==NUM_DIGITS
- ovf  output  1  one-cycle pulse: a push was rejected because the entry was full
- done  output  1  one-cycle pulse: a commit took effect

## Operation
- Reset (rst=0 at an edge): live, dout, count, ovf and done go to 0; empty=1; full=0. Reset overrides every command.
- Command decode each edge, in strict priority: clr > commit > pop/push. Lower-priority commands in the same cycle are dropped.
- clr:
  - live=0, count=0
  - dout is unchanged; ovf=0, done=0
- commit:
  - dout ← live, then live=0, count=0, done=1
  - Commit while empty is legal: dout ← 0 and done still pulses.
- push only, when not full:
  - live shifts up one digit; digit k ← digit k-1
  - digit 0 ← din
  - count+1
- push only, when full: live and count are unchanged; ovf=1.
- pop only, when not empty:
  - live shifts down one digit; digit k ← digit k+1
  - top digit ← 0
  - count-1
- pop only, when empty: no change and no flag.
- push and pop in the same cycle: no change to live or count; no ovf.
- din is ignored unless a push takes effect.
- Unused high digits always read 0, so live is the entered number right-aligned.
- ovf and done are 0 in every cycle where they are not explicitly set.

## Timing
- All outputs are registered. A command sampled at edge N is visible on all outputs after edge N; there are no combinational input-to-output paths.
- Back-to-back commands on consecutive cycles are supported at full rate, including a push on the cycle immediately after a commit, which lands in the cleared entry.
- empty and full are registered and consistent with count in the same cycle.
- A reset asserted mid-entry or mid-commit clears everything at that edge. No partial commit is ever visible on dout.
- dout changes only on a commit edge or a reset edge.

## Structure
- Shared package digit_pkg:
  - the DIGIT_W default
  - the priority-encoded command enum: CMD_NONE, CMD_CLR, CMD_COMMIT, CMD_PUSH, CMD_POP, CMD_HOLD (for push+pop)
  - a digit_t typedef
- A small combinational decoder in this module maps the four command inputs to the enum.
- One sub-module, digit_slot: a single DIGIT_W register with sync active-low reset and a 4-way next-value mux (hold / from-lower / from-upper / zero). It is instantiated NUM_DIGITS times with generate. Slot 0's "from-lower" input is din; the top slot's "from-upper" input is 0.
- The committed register, count logic and the ovf/done flags live at top level.

## Test plan
Default parameters unless noted.
- Reset and single-digit entry:
  - stimulus: hold rst=0 for 2 cycles, release, push din=3, push din=7
  - required: live=0x0037, count=2, empty=0, dout=0
- Overflow and priority:
  - stimulus: push 1,2,3,4, then push 5; then clr and push in the same cycle
  - required after the fifth push: live=0x1234, full=1, ovf=1 for exactly one cycle
  - required after clr+push: live=0, count=0, ovf=0
- Backspace:
  - stimulus: from live=0x1234, pop twice, then pop on empty
  - required: live=0x0012, count=2; a later pop on empty leaves state unchanged with no flags
- Commit:
  - stimulus: push 9,8, commit, then push 5 on the next cycle
  - required: dout=0x0098, done=1 for one cycle, then live=0x0005 while dout stays 0x0098
- Simultaneous commands and mid-operation reset:
  - stimulus: push+pop together; then commit+push together
  - required: push+pop leaves live unchanged; commit+push commits the pre-push value and drops din
  - stimulus: rst=0 while count=3 and commit=1
  - required: dout=0, live=0, done=0
- Parameter sweep:
  - stimulus: DIGIT_W=1, NUM_DIGITS=8; push 8 bits, then a 9th
  - required: live equals the pushed bits in order, count width is 4 bits, full=1, ovf pulses on the 9th push
